// File: rtl/seg7_scan_capture.sv
// Captures the four digits shown on a multiplexed 7-segment display bus.
// Each glyph must hold steady for STABLE_CYCLES samples; a complete set of digits is published as one frame.
module seg7_scan_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter bit ERR_ON_BLANK  = 1'b0
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic [3:0]  i_Anodos,
    input  logic [6:0]  i_Segmentos,
    output logic [15:0] o_Valor,
    output logic        o_Frame_valid,
    output logic [3:0]  o_Digit_err,
    output logic        o_Busy
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_cfg_err
        $error("seg7_scan_capture: STABLE_CYCLES must be within 2..255");
    end

    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

    state_t          state;
    logic [3:0]      anod_s1, anod_s2;
    logic [6:0]      seg_s1, seg_s2;
    logic [1:0]      idx;
    logic [6:0]      pat;
    logic [7:0]      cnt;
    logic [3:0][3:0] slots;
    logic [3:0]      captured;
    logic [3:0]      err_pend;

    logic            sel;
    logic [1:0]      sel_idx;
    logic            same;
    logic            capture;
    logic [4:0]      decoded;

    // Returns {invalid, value}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   decode = 5'h00;
            7'h06:   decode = 5'h01;
            7'h5B:   decode = 5'h02;
            7'h4F:   decode = 5'h03;
            7'h66:   decode = 5'h04;
            7'h6D:   decode = 5'h05;
            7'h7D:   decode = 5'h06;
            7'h07:   decode = 5'h07;
            7'h7F:   decode = 5'h08;
            7'h6F:   decode = 5'h09;
            7'h77:   decode = 5'h0A;
            7'h7C:   decode = 5'h0B;
            7'h39:   decode = 5'h0C;
            7'h5E:   decode = 5'h0D;
            7'h79:   decode = 5'h0E;
            7'h71:   decode = 5'h0F;
            7'h00:   decode = {ERR_ON_BLANK, 4'h0};
            default: decode = 5'h10;
        endcase
    endfunction

    // Only a single active-low anode counts as a selected digit.
    always_comb begin
        sel     = 1'b1;
        sel_idx = 2'd0;
        case (anod_s2)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel     = 1'b0;
        endcase
    end

    assign same    = sel && (sel_idx == idx) && (seg_s2 == pat);
    assign capture = (state == TRACK) && same && (cnt >= LAST_CNT);
    assign decoded = decode(pat);
    assign o_Busy  = (state == TRACK);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state         <= IDLE;
            anod_s1       <= '0;
            anod_s2       <= '0;
            seg_s1        <= '0;
            seg_s2        <= '0;
            idx           <= '0;
            pat           <= '0;
            cnt           <= '0;
            slots         <= '0;
            captured      <= '0;
            err_pend      <= '0;
            o_Valor       <= '0;
            o_Frame_valid <= 1'b0;
            o_Digit_err   <= '0;
        end else begin
            anod_s1       <= i_Anodos;
            anod_s2       <= anod_s1;
            seg_s1        <= i_Segmentos;
            seg_s2        <= seg_s1;
            o_Frame_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (sel) begin
                        idx   <= sel_idx;
                        pat   <= seg_s2;
                        cnt   <= 8'd1;
                        state <= TRACK;
                    end
                end
                TRACK: begin
                    if (!sel) begin
                        state <= IDLE;
                    end else if (!same) begin
                        idx <= sel_idx;
                        pat <= seg_s2;
                        cnt <= 8'd1;
                    end else if (capture) begin
                        state <= HOLD;
                    end else if (cnt != 8'hFF) begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (!sel) begin
                        state <= IDLE;
                    end else if (!same) begin
                        idx   <= sel_idx;
                        pat   <= seg_s2;
                        cnt   <= 8'd1;
                        state <= TRACK;
                    end
                end
                default: state <= IDLE;
            endcase

            if (captured == 4'hF) begin
                o_Valor       <= slots;
                o_Digit_err   <= err_pend;
                o_Frame_valid <= 1'b1;
                captured      <= '0;
                err_pend      <= '0;
            end

            // NOTE: the later non-blocking bit writes override the clears above, so a capture coinciding with a frame publish starts the next frame.
            if (capture) begin
                slots[idx]    <= decoded[3:0];
                err_pend[idx] <= decoded[4];
                captured[idx] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture: scans hand-built frames and checks the published values.
module tb_seg7_scan_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  anod;
    logic [6:0]  seg;
    logic [15:0] valor, b_valor;
    logic        fv, b_fv;
    logic [3:0]  derr, b_derr;
    logic        busy, b_busy;

    int total = 0;
    int bad   = 0;
    int frames = 0;
    int b_frames = 0;
    int busy_cycles = 0;
    int f0, b0;

    localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111, OFF = 4'b1111;

    always #5 clk = ~clk;

    seg7_scan_capture #(.STABLE_CYCLES(4), .ERR_ON_BLANK(1'b0)) u_dut (
        .i_Clk(clk), .i_Rst(rst), .i_Anodos(anod), .i_Segmentos(seg),
        .o_Valor(valor), .o_Frame_valid(fv), .o_Digit_err(derr), .o_Busy(busy)
    );

    seg7_scan_capture #(.STABLE_CYCLES(4), .ERR_ON_BLANK(1'b1)) u_blank (
        .i_Clk(clk), .i_Rst(rst), .i_Anodos(anod), .i_Segmentos(seg),
        .o_Valor(b_valor), .o_Frame_valid(b_fv), .o_Digit_err(b_derr), .o_Busy(b_busy)
    );

    always @(negedge clk) begin
        if (fv)   frames++;
        if (b_fv) b_frames++;
        if (busy) busy_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic show(input logic [3:0] an, input logic [6:0] sg, input int n);
        anod = an;
        seg  = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                         input logic [6:0] p2, input logic [6:0] p3);
        show(D0, p0, 6);
        show(D1, p1, 6);
        show(D2, p2, 6);
        show(D3, p3, 6);
        show(OFF, 7'h00, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst  = 1'b1;
        anod = OFF;
        seg  = 7'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valor", valor, 16'h0000);
        check("rst_fv", fv, 1'b0);
        check("rst_err", derr, 4'h0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;

        // First digit split in two to observe busy while qualifying and after capture.
        f0 = frames;
        show(D0, 7'h3F, 4);
        check("busy_tracking", busy, 1'b1);
        show(D0, 7'h3F, 2);
        check("busy_after_capture", busy, 1'b0);
        show(D1, 7'h06, 6);
        show(D2, 7'h5B, 6);
        show(D3, 7'h4F, 6);
        show(OFF, 7'h00, 4);
        check("warmup_frames", frames - f0, 1);
        check("warmup_valor", valor, 16'h3210);

        // Basic scan.
        f0 = frames;
        frame(7'h06, 7'h5B, 7'h4F, 7'h66);
        check("scan_frames", frames - f0, 1);
        check("scan_valor", valor, 16'h4321);
        check("scan_err", derr, 4'h0);
        check("scan_fv_low", fv, 1'b0);

        // Short dwell on digit 2 is not enough.
        f0 = frames;
        show(D0, 7'h06, 6);
        show(D1, 7'h5B, 6);
        show(D2, 7'h4F, 3);
        show(D3, 7'h66, 6);
        show(OFF, 7'h00, 4);
        check("short_no_frame", frames - f0, 0);
        check("short_valor_kept", valor, 16'h4321);
        show(D2, 7'h4F, 6);
        show(OFF, 7'h00, 4);
        check("short_completed", frames - f0, 1);
        check("short_valor", valor, 16'h4321);

        // Invalid glyph on digit 1, then a clean frame clears the flag.
        f0 = frames;
        frame(7'h3F, 7'h55, 7'h5B, 7'h4F);
        check("bad_frames", frames - f0, 1);
        check("bad_valor", valor, 16'h3200);
        check("bad_err", derr, 4'b0010);
        frame(7'h7D, 7'h6D, 7'h6F, 7'h07);
        check("clean_frames", frames - f0, 2);
        check("clean_valor", valor, 16'h7956);
        check("clean_err", derr, 4'h0);

        // All anodes active is idle.
        f0 = frames;
        b0 = busy_cycles;
        show(4'b0000, 7'h3F, 20);
        check("idle_busy", busy_cycles - b0, 0);
        check("idle_frames", frames - f0, 0);

        // Long dwell captures once.
        show(OFF, 7'h00, 4);
        b0 = busy_cycles;
        show(D0, 7'h7F, 100);
        check("long_busy_cycles", busy_cycles - b0, 3);
        show(D1, 7'h06, 6);
        show(D2, 7'h5B, 6);
        show(D3, 7'h4F, 6);
        show(OFF, 7'h00, 4);
        check("long_frames", frames - f0, 1);
        check("long_valor", valor, 16'h3218);

        // Remaining glyphs.
        f0 = frames;
        frame(7'h79, 7'h71, 7'h7F, 7'h3F);
        check("hex_frames", frames - f0, 1);
        check("hex_valor", valor, 16'h08FE);

        // Blank glyph: error only on the ERR_ON_BLANK instance.
        b0 = b_frames;
        frame(7'h3F, 7'h06, 7'h00, 7'h4F);
        check("blank_valor", valor, 16'h3010);
        check("blank_err", derr, 4'h0);
        check("blank_b_frames", b_frames - b0, 1);
        check("blank_b_valor", b_valor, 16'h3010);
        check("blank_b_err", b_derr, 4'b0100);
        check("blank_b_busy", b_busy, busy);

        // Reset mid-frame discards the partial capture.
        f0 = frames;
        show(D0, 7'h7D, 6);
        show(D1, 7'h6D, 6);
        show(D2, 7'h66, 6);
        anod = OFF;
        rst  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("mid_rst_valor", valor, 16'h0000);
        check("mid_rst_err", derr, 4'h0);
        check("mid_rst_busy", busy, 1'b0);
        rst = 1'b0;
        frame(7'h77, 7'h7C, 7'h39, 7'h5E);
        check("post_rst_frames", frames - f0, 1);
        check("post_rst_valor", valor, 16'hDCBA);
        check("post_rst_err", derr, 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_capture.md
SEG7_SCAN_CAPTURE -- requirements
Module: seg7_scan_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, sets the consecutive identical sampled cycles (2..255) needed to accept a digit.
REQ-002 Parameter ERR_ON_BLANK, default 0; when 1, an all-off pattern (0x00) counts as an invalid glyph.
REQ-003 i_Clk  input  1  single system clock; all logic on its rising edge.
REQ-004 i_Rst  input  1  reset, synchronous and active-high.
REQ-005 i_Anodos  input  4  digit enables from the scanned display bus, active-low, bit n = digit n.
REQ-006 i_Segmentos  input  7  segment lines, active-high, bit order g..a (bit0 = a).
REQ-007 o_Valor  output  16  captured frame, digit n in bits [4n+3:4n].
REQ-008 o_Frame_valid  output  1  one-cycle pulse when o_Valor updates.
REQ-009 o_Digit_err  output  4  sticky per-digit invalid-glyph flags for the current frame.
REQ-010 o_Busy  output  1  high while a digit is being qualified.

Function
REQ-011 i_Anodos and i_Segmentos SHALL pass through a two-flop synchronizer; all decisions use the synchronized values (2-cycle input latency).
REQ-012 A sample is "selected" only when exactly one i_Anodos bit is low; zero or multiple low bits are "idle" samples.
REQ-013 The FSM has states IDLE, TRACK, HOLD.
REQ-014 IDLE: on a selected sample, latch anode index and pattern, load the stability counter with 1, go to TRACK.
REQ-015 TRACK: same index and pattern -> increment counter; any change -> reload with the new selection (counter 1, stay in TRACK) or go to IDLE if idle.
REQ-016 TRACK: when the counter reaches STABLE_CYCLES, decode the pattern, write the digit slot, set its captured bit, go to HOLD.
REQ-017 HOLD: stay while the same index and pattern persist; leave to IDLE on idle, or to TRACK (counter 1) on any new selection; a digit is captured at most once per continuous display dwell.
REQ-018 Decode table (hex pattern -> value): 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7, 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F.
REQ-019 Any other pattern writes 0x0 to the slot and sets o_Digit_err[n]; 0x00 is invalid only when ERR_ON_BLANK=1, otherwise it writes 0x0 with no error.
REQ-020 When all four captured bits are set, on the next cycle o_Valor takes the four slots, o_Frame_valid pulses high for one cycle, and the captured bits clear.
REQ-021 o_Digit_err updates together with o_Valor, reflecting that frame's errors, and holds until the next frame.
REQ-022 Recapturing an already-captured digit before the frame completes overwrites its slot and error bit; the captured bit stays set.
REQ-023 o_Busy = 1 exactly when the FSM is in TRACK.
REQ-024 The counter saturates and never wraps; STABLE_CYCLES outside 2..255 is a configuration error.

Reset
REQ-025 While i_Rst is high at a clock edge: FSM -> IDLE, counter, slots, captured bits and synchronizers -> 0; o_Valor = 0x0000, o_Frame_valid = 0, o_Digit_err = 0, o_Busy = 0.
REQ-026 Reset asserted mid-TRACK or mid-frame discards partial captures; no o_Frame_valid pulse is produced for that frame.

Verification
REQ-027 Scan digits 0..3 with patterns 06,5B,4F,66, 6 cycles each -> single o_Frame_valid pulse, o_Valor = 0x4321, o_Digit_err = 0.
REQ-028 Digit 2 dwell of only 3 cycles (STABLE_CYCLES=4), the rest 6 cycles -> no frame; a later full 6-cycle dwell on digit 2 completes the frame.
REQ-029 Digit 1 shows pattern 0x55 -> frame with slot1 = 0x0, o_Digit_err = 4'b0010; the next clean frame clears it.
REQ-030 i_Anodos = 4'b0000 for 20 cycles -> FSM stays in IDLE, o_Busy = 0, no capture.
REQ-031 Hold digit 0 = 0x7F for 100 cycles -> exactly one capture of value 8, no repeated writes.
REQ-032 Assert i_Rst after three digits are captured, then scan one full frame -> exactly one o_Frame_valid pulse, with the post-reset values only.
